// File: rtl/apb_bridge_pkg.sv
// Shared types for the AXI4-Lite to APB bridge.
// Contents: scheduler FSM states, arbiter grant ids and APB response codes.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Grant ids double as bit positions in the two-bit request/grant vectors.
    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/apb_rw_scheduler_if.sv
// Signal bundle between the scheduler, its request/response FIFOs and the APB bus.
// The master modport is the scheduler's view; slave is the FIFO/APB-slave side.
interface apb_rw_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic [2:0]        wr_prot;
    logic              wr_pop;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_prot;
    logic              rd_pop;

    logic              b_full;
    logic              b_push;
    logic [1:0]        b_resp;

    logic              r_full;
    logic              r_push;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;

    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [2:0]        pprot;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  wr_req, wr_addr, wr_data, wr_strb, wr_prot,
        output wr_pop,
        input  rd_req, rd_addr, rd_prot,
        output rd_pop,
        input  b_full,
        output b_push, b_resp,
        input  r_full,
        output r_push, r_data, r_resp,
        output paddr, pwdata, pstrb, pprot, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        output wr_req, wr_addr, wr_data, wr_strb, wr_prot,
        input  wr_pop,
        output rd_req, rd_addr, rd_prot,
        input  rd_pop,
        output b_full,
        input  b_push, b_resp,
        output r_full,
        input  r_push, r_data, r_resp,
        input  paddr, pwdata, pstrb, pprot, pwrite, psel, penable,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_rw_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; bit GNT_WR is the write path, GNT_RD the read path.
// Priority moves to the other requester whenever advance is pulsed.
module rr_arb2
    import apb_bridge_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    grant_t prio;

    always_comb begin
        gnt = 2'b00;
        if (req[GNT_WR] && req[GNT_RD]) begin
            gnt[prio] = 1'b1;
        end else if (req[GNT_WR]) begin
            gnt[GNT_WR] = 1'b1;
        end else if (req[GNT_RD]) begin
            gnt[GNT_RD] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= GNT_WR;
        end else if (advance) begin
            prio <= gnt[GNT_WR] ? GNT_RD : GNT_WR;
        end
    end

endmodule

// File: rtl/apb_rw_scheduler.sv
// Shares one APB master port between the AXI4-Lite write and read paths.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES without pready.
module apb_rw_scheduler
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    apb_rw_scheduler_if.master  bus
);

    localparam int STRB_W = DATA_W / 8;

    if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("apb_rw_scheduler: TIMEOUT_CYCLES must be at least 2");
    end

    state_t            state, state_nxt;
    logic [1:0]        elig, arb_req, gnt;
    logic              done, timed_out;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [STRB_W-1:0] pstrb_q;
    logic [2:0]        pprot_q;
    logic              pwrite_q;

    // A response slot must be free before a transfer may start.
    assign elig[GNT_WR] = bus.wr_req & ~bus.b_full;
    assign elig[GNT_RD] = bus.rd_req & ~bus.r_full;

    // Outside IDLE the arbiter sees only the in-flight owner, so advance hands
    // priority to the other side when that transfer completes.
    assign arb_req = (state == IDLE) ? (rst ? 2'b00 : elig)
                                     : (pwrite_q ? 2'b01 : 2'b10);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (done),
        .gnt     (gnt)
    );

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state != ACCESS) begin
            tmo_cnt <= '0;
        end else if (!bus.pready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timed_out = (state == ACCESS) && !bus.pready &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    assign done = (state == ACCESS) && (bus.pready || timed_out);

    always_comb begin
        state_nxt  = state;
        bus.wr_pop = 1'b0;
        bus.rd_pop = 1'b0;
        bus.b_push = 1'b0;
        bus.b_resp = RESP_OKAY;
        bus.r_push = 1'b0;
        bus.r_resp = RESP_OKAY;
        bus.r_data = '0;
        unique case (state)
            IDLE: begin
                if (gnt[GNT_WR]) begin
                    bus.wr_pop = 1'b1;
                    state_nxt  = SETUP;
                end else if (gnt[GNT_RD]) begin
                    bus.rd_pop = 1'b1;
                    state_nxt  = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (done) begin
                    state_nxt = IDLE;
                    // A pready on the expiry cycle beats the timeout.
                    if (pwrite_q) begin
                        bus.b_push = 1'b1;
                        bus.b_resp = bus.pready ? resp_of(bus.pslverr) : RESP_SLVERR;
                    end else begin
                        bus.r_push = 1'b1;
                        bus.r_resp = bus.pready ? resp_of(bus.pslverr) : RESP_SLVERR;
                        bus.r_data = bus.pready ? bus.prdata : '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && gnt[GNT_WR]) begin
                paddr_q  <= bus.wr_addr;
                pwdata_q <= bus.wr_data;
                pstrb_q  <= bus.wr_strb;
                pprot_q  <= bus.wr_prot;
                pwrite_q <= 1'b1;
            end else if (state == IDLE && gnt[GNT_RD]) begin
                paddr_q  <= bus.rd_addr;
                pwdata_q <= '0;
                pstrb_q  <= '0;
                pprot_q  <= bus.rd_prot;
                pwrite_q <= 1'b0;
            end
        end
    end

    assign bus.psel    = (state != IDLE);
    assign bus.penable = (state == ACCESS);
    assign bus.paddr   = paddr_q;
    assign bus.pwdata  = pwdata_q;
    assign bus.pstrb   = pstrb_q;
    assign bus.pprot   = pprot_q;
    assign bus.pwrite  = pwrite_q;

endmodule

// File: tb/tb_apb_rw_scheduler.sv
// Bench for apb_rw_scheduler: directed table of transfers, hand sequences for
// reset/timeout corners, then random transfers checked against a grant-order model.
module tb_apb_rw_scheduler;
    import apb_bridge_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef APB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    typedef struct {
        bit          wr_req, rd_req, b_full, r_full, err;
        int          waits;
        logic [31:0] waddr, wdata, raddr, rdat;
        logic [3:0]  strb;
        logic [2:0]  wprot, rprot;
        int          exp_gnt;   // 0 none, 1 write, 2 read
        logic [1:0]  exp_resp;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    apb_rw_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_rw_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    n_cmp  = 0;
    int    n_fail = 0;
    bit    last_wr;          // model: direction of the most recent grant
    xfer_t vecs[12];
    xfer_t t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Round-robin rule: with both eligible, grant the side opposite the last grant.
    function automatic int pick(bit we, bit re, bit lw);
        if (we && re) return lw ? 2 : 1;
        if (we) return 1;
        if (re) return 2;
        return 0;
    endfunction

    function automatic xfer_t mk(bit w, bit r, bit bf, bit rf, bit err, int g,
                                 logic [1:0] resp, int i);
        xfer_t x;
        x.wr_req = w;  x.rd_req = r;  x.b_full = bf;  x.r_full = rf;  x.err = err;
        x.waits  = i % 3;
        x.waddr  = 32'h1000 + 32'(i) * 32'h10;
        x.wdata  = 32'hC0DE_0000 + 32'(i);
        x.raddr  = 32'h2000 + 32'(i) * 32'h10;
        x.rdat   = 32'hBEEF_0000 + 32'(i);
        x.strb   = 4'(i + 1);
        x.wprot  = 3'(i);
        x.rprot  = 3'(7 - i);
        x.exp_gnt  = g;
        x.exp_resp = resp;
        return x;
    endfunction

    task automatic idle_inputs();
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0; bus.wr_prot = '0;
        bus.rd_req = 0; bus.rd_addr = '0; bus.rd_prot = '0;
        bus.b_full = 0; bus.r_full = 0;
        bus.prdata = '0; bus.pready = 0; bus.pslverr = 0;
    endtask

    // Entered just after a rising edge with the DUT in IDLE; leaves it the same way.
    task automatic do_xfer(input xfer_t x, input string tag);
        bit          is_wr;
        logic [31:0] exp_addr;
        bus.wr_req = x.wr_req; bus.rd_req = x.rd_req;
        bus.b_full = x.b_full; bus.r_full = x.r_full;
        bus.wr_addr = x.waddr; bus.wr_data = x.wdata; bus.wr_strb = x.strb; bus.wr_prot = x.wprot;
        bus.rd_addr = x.raddr; bus.rd_prot = x.rprot;
        bus.pready = 0; bus.pslverr = 0;
        @(negedge clk);
        chk({tag, ".idle_psel"}, bus.psel, 0);
        chk({tag, ".wr_pop"}, bus.wr_pop, x.exp_gnt == 1);
        chk({tag, ".rd_pop"}, bus.rd_pop, x.exp_gnt == 2);
        @(posedge clk); #1;
        if (x.exp_gnt == 0) return;
        is_wr    = (x.exp_gnt == 1);
        last_wr  = is_wr;
        exp_addr = is_wr ? x.waddr : x.raddr;
        // FIFO heads move on after the pop; the latched APB fields must not follow.
        bus.wr_req = 0; bus.rd_req = 0;
        bus.wr_addr = ~x.waddr; bus.wr_data = ~x.wdata; bus.wr_strb = ~x.strb; bus.rd_addr = ~x.raddr;
        @(negedge clk);
        chk({tag, ".setup_psel"}, bus.psel, 1);
        chk({tag, ".setup_penable"}, bus.penable, 0);
        chk({tag, ".paddr"}, bus.paddr, exp_addr);
        chk({tag, ".pwrite"}, bus.pwrite, is_wr);
        chk({tag, ".pstrb"}, bus.pstrb, is_wr ? x.strb : 4'h0);
        chk({tag, ".pprot"}, bus.pprot, is_wr ? x.wprot : x.rprot);
        if (is_wr) chk({tag, ".pwdata"}, bus.pwdata, x.wdata);
        chk({tag, ".setup_pops"}, {bus.wr_pop, bus.rd_pop}, 2'b00);
        @(posedge clk); #1;
        for (int k = 0; k < x.waits; k++) begin
            @(negedge clk);
            chk({tag, ".wait_en"}, {bus.psel, bus.penable}, 2'b11);
            chk({tag, ".wait_paddr"}, bus.paddr, exp_addr);
            chk({tag, ".wait_push"}, {bus.b_push, bus.r_push}, 2'b00);
            @(posedge clk); #1;
        end
        bus.pready = 1; bus.pslverr = x.err; bus.prdata = x.rdat;
        @(negedge clk);
        chk({tag, ".acc_penable"}, bus.penable, 1);
        chk({tag, ".push"}, {bus.b_push, bus.r_push}, is_wr ? 2'b10 : 2'b01);
        chk({tag, ".resp"}, is_wr ? bus.b_resp : bus.r_resp, x.exp_resp);
        if (!is_wr) chk({tag, ".r_data"}, bus.r_data, x.rdat);
        @(posedge clk); #1;
        bus.pready = 0; bus.pslverr = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        bus.wr_req = 1; bus.rd_req = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.psel_penable", {bus.psel, bus.penable}, 2'b00);
        chk("rst.pops", {bus.wr_pop, bus.rd_pop}, 2'b00);
        chk("rst.pushes", {bus.b_push, bus.r_push}, 2'b00);
        chk("rst.paddr", bus.paddr, 0);
        chk("rst.pwdata_pstrb", {bus.pwdata, bus.pstrb, bus.pprot, bus.pwrite}, 0);
        rst = 0;
        bus.wr_req = 0; bus.rd_req = 0;
        @(posedge clk); #1;

        t = mk(1, 0, 0, 0, 0, 1, RESP_OKAY, 0);
        t.waddr = 32'h10; t.wdata = 32'hA5A5_A5A5; t.strb = 4'hF; t.waits = 0;
        do_xfer(t, "single_wr");
        t = mk(0, 1, 0, 0, 0, 2, RESP_OKAY, 0);
        t.raddr = 32'h20; t.rdat = 32'hDEAD_BEEF; t.waits = 3;
        do_xfer(t, "read_3ws");

        vecs[0]  = mk(1, 1, 0, 0, 0, 1, RESP_OKAY,   0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 2, RESP_OKAY,   1);
        vecs[2]  = mk(1, 1, 0, 0, 1, 1, RESP_SLVERR, 2);
        vecs[3]  = mk(1, 1, 0, 0, 0, 2, RESP_OKAY,   3);
        vecs[4]  = mk(1, 1, 1, 0, 0, 2, RESP_OKAY,   4);
        vecs[5]  = mk(1, 0, 0, 0, 0, 1, RESP_OKAY,   5);
        vecs[6]  = mk(0, 1, 0, 0, 1, 2, RESP_SLVERR, 6);
        vecs[7]  = mk(1, 1, 1, 1, 0, 0, RESP_OKAY,   7);
        vecs[8]  = mk(1, 0, 1, 0, 0, 0, RESP_OKAY,   8);
        vecs[9]  = mk(1, 1, 0, 0, 0, 1, RESP_OKAY,   9);
        vecs[10] = mk(0, 1, 0, 1, 0, 0, RESP_OKAY,   10);
        vecs[11] = mk(1, 1, 0, 0, 0, 2, RESP_OKAY,   11);
        for (int i = 0; i < 12; i++) do_xfer(vecs[i], $sformatf("vec%0d", i));
        idle_inputs();

        // Reset while a write sits in ACCESS: drop it, no response.
        t = mk(1, 0, 0, 0, 0, 1, RESP_OKAY, 20);
        bus.wr_req = 1; bus.wr_addr = t.waddr; bus.wr_data = t.wdata; bus.wr_strb = t.strb;
        @(negedge clk);
        chk("rstmid.wr_pop", bus.wr_pop, 1);
        @(posedge clk); #1;
        bus.wr_req = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid.in_access", {bus.psel, bus.penable}, 2'b11);
        #1 rst = 1; bus.pready = 1;
        #1;
        chk("rstmid.psel_drop", {bus.psel, bus.penable}, 2'b00);
        chk("rstmid.no_push", {bus.b_push, bus.r_push}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        chk("rstmid.no_push2", {bus.b_push, bus.r_push}, 2'b00);
        chk("rstmid.paddr", bus.paddr, 0);
        rst = 0; bus.pready = 0;
        @(posedge clk); #1;
        last_wr = 0;

`ifdef APB_TIMEOUT_EN
        t = mk(1, 0, 0, 0, 0, 1, RESP_SLVERR, 30);
        bus.wr_req = 1; bus.wr_addr = t.waddr; bus.wr_data = t.wdata; bus.wr_strb = t.strb;
        @(negedge clk);
        chk("tmo.wr_pop", bus.wr_pop, 1);
        @(posedge clk); #1;
        bus.wr_req = 0;
        @(posedge clk); #1;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            chk("tmo.psel", {bus.psel, bus.penable}, 2'b11);
            chk("tmo.b_push", bus.b_push, k == TMO - 1);
            if (k == TMO - 1) chk("tmo.b_resp", bus.b_resp, RESP_SLVERR);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tmo.psel_drop", {bus.psel, bus.penable}, 2'b00);
        @(posedge clk); #1;
        last_wr = 1;
        t = mk(0, 1, 0, 0, 0, 2, RESP_OKAY, 31);
        t.waits = TMO - 1;
        do_xfer(t, "tmo_ready_wins");
`endif

        for (int i = 0; i < 300; i++) begin
            t = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, 0, RESP_OKAY, i);
            t.waddr = $urandom; t.wdata = $urandom; t.raddr = $urandom; t.rdat = $urandom;
            t.strb  = 4'($urandom); t.wprot = 3'($urandom); t.rprot = 3'($urandom);
            t.waits = $urandom_range(0, 3);
            t.exp_gnt  = pick(t.wr_req & ~t.b_full, t.rd_req & ~t.r_full, last_wr);
            t.exp_resp = t.err ? 2'b10 : 2'b00;
            do_xfer(t, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
